// File: rtl/systolic_pe_out_sink_if.sv
// systolic_pe_out_sink_if: valid/ready result stream leaving the PE output sink.
interface systolic_pe_out_sink_if;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    modport master (output dout, dout_valid, input dout_ready);
    modport slave (input dout, dout_valid, output dout_ready);
endinterface

// File: rtl/systolic_pe_out_sink.sv
// systolic_pe_out_sink: samples PE yout once per sample period, scales it and buffers it in a show-ahead FIFO.
// Define PE_OUT_ROUND_EN to round half up before the right shift instead of truncating.
module systolic_pe_out_sink #(
    parameter int SAMPLE_PERIOD = 30,
    parameter int CAPTURE_PHASE = 29,
    parameter int SHIFT = 0,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk30x,
    input  logic                          rst,
    input  logic                          en,
    input  logic [15:0]                   yin,
    systolic_pe_out_sink_if.master        res,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [15:0]                   capture_count,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = $clog2(SAMPLE_PERIOD);
    logic [PW-1:0] ph;
    logic [15:0]   stage;
    logic          push_pend;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [16:0]   ext, rnd, shf;
    logic [31:0]   proc;
    logic          capture, push, pop;
    assign capture = en && (ph == PW'(CAPTURE_PHASE));
    assign ext = {stage[15], stage};
`ifdef PE_OUT_ROUND_EN
    localparam logic [16:0] HALF = 17'((1 << SHIFT) >> 1);
    assign rnd = ext + HALF;
`else
    assign rnd = ext;
`endif
    assign shf = $signed(rnd) >>> SHIFT;
    assign proc = {{15{shf[16]}}, shf};
    // Count MSB set means exactly FIFO_DEPTH entries held.
    assign pop = res.dout_valid && res.dout_ready;
    assign push = push_pend && (!fifo_count[AW] || pop);
    assign res.dout_valid = fifo_count != '0;
    // While empty, show the most recently popped entry so dout holds its value.
    assign res.dout = res.dout_valid ? mem[rp] : mem[rp - AW'(1)];
    always_ff @(posedge clk30x) begin
        if (rst) begin
            ph <= '0;
            stage <= '0;
            push_pend <= 1'b0;
            capture_count <= '0;
            overflow <= 1'b0;
            wp <= '0;
            rp <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (en) ph <= (ph == PW'(SAMPLE_PERIOD - 1)) ? '0 : ph + PW'(1);
            push_pend <= capture;
            if (capture) begin
                stage <= yin;
                capture_count <= capture_count + 16'd1;
            end
            if (push) begin
                mem[wp] <= proc;
                wp <= wp + AW'(1);
            end
            if (push_pend && !push) overflow <= 1'b1;
            if (pop) rp <= rp + AW'(1);
            fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_systolic_pe_out_sink.sv
// tb_systolic_pe_out_sink: directed checks of capture timing, scaling, FIFO overrun and reset for systolic_pe_out_sink.
module tb_systolic_pe_out_sink;
    logic clk30x = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic [15:0] yin = 16'h1234;
    logic [3:0] cnt0, cnt2;
    logic [15:0] cc0, cc2;
    logic ovf0, ovf2;
    int n_cmp = 0;
    int n_err = 0;
    systolic_pe_out_sink_if b0 ();
    systolic_pe_out_sink_if b2 ();
    systolic_pe_out_sink u0 (.clk30x(clk30x), .rst(rst), .en(en), .yin(yin), .res(b0),
                             .fifo_count(cnt0), .capture_count(cc0), .overflow(ovf0));
    systolic_pe_out_sink #(.SHIFT(2)) u2 (.clk30x(clk30x), .rst(rst), .en(en), .yin(yin), .res(b2),
                             .fifo_count(cnt2), .capture_count(cc2), .overflow(ovf2));
    always #5 clk30x = ~clk30x;
`ifdef PE_OUT_ROUND_EN
    localparam logic [31:0] NEG6_S2 = 32'hFFFFFFFF;
    localparam logic [31:0] POS6_S2 = 32'h00000002;
`else
    localparam logic [31:0] NEG6_S2 = 32'hFFFFFFFE;
    localparam logic [31:0] POS6_S2 = 32'h00000001;
`endif
    task automatic tick(input int n);
        repeat (n) @(negedge clk30x);
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask
    task automatic restart();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        en = 1'b1;
    endtask
    initial begin
        b0.dout_ready = 1'b0;
        b2.dout_ready = 1'b0;
        tick(2);
        chk("rst_dout", b0.dout, 32'h0);
        chk("rst_valid", 32'(b0.dout_valid), 32'h0);
        chk("rst_count", 32'(cnt0), 32'h0);
        chk("rst_cc", 32'(cc0), 32'h0);
        chk("rst_ovf", 32'(ovf0), 32'h0);
        rst = 1'b0;
        en = 1'b1;
        tick(29);
        chk("cc_before_first", 32'(cc0), 32'h0);
        tick(1);
        chk("cc_first", 32'(cc0), 32'h1);
        chk("valid_not_yet", 32'(b0.dout_valid), 32'h0);
        tick(1);
        chk("valid_first", 32'(b0.dout_valid), 32'h1);
        chk("dout_first", b0.dout, 32'h00001234);
        chk("count_first", 32'(cnt0), 32'h1);
        chk("dout_first_s2", b2.dout, 32'h0000048D);
        yin = 16'hFFFA;
        b0.dout_ready = 1'b1;
        b2.dout_ready = 1'b1;
        tick(30);
        chk("sign_ext", b0.dout, 32'hFFFFFFFA);
        chk("neg_s2", b2.dout, NEG6_S2);
        yin = 16'h0006;
        tick(1);
        chk("empty_valid", 32'(b0.dout_valid), 32'h0);
        chk("empty_count", 32'(cnt0), 32'h0);
        chk("empty_hold", b0.dout, 32'hFFFFFFFA);
        tick(29);
        chk("pos_s0", b0.dout, 32'h00000006);
        chk("pos_s2", b2.dout, POS6_S2);
        b0.dout_ready = 1'b0;
        b2.dout_ready = 1'b0;
        restart();
        for (int i = 1; i <= 9; i++) begin
            yin = 16'(i);
            tick(30);
        end
        tick(1);
        chk("ovr_count", 32'(cnt0), 32'h8);
        chk("ovr_flag", 32'(ovf0), 32'h1);
        chk("ovr_cc", 32'(cc0), 32'h9);
        b0.dout_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("ovr_drain", b0.dout, 32'(i));
            tick(1);
        end
        chk("ovr_empty", 32'(b0.dout_valid), 32'h0);
        chk("ovr_last", b0.dout, 32'h8);
        b0.dout_ready = 1'b0;
        restart();
        for (int i = 1; i <= 8; i++) begin
            yin = 16'(16'h10 + i);
            tick(30);
        end
        yin = 16'h0099;
        tick(30);
        chk("full_before", 32'(cnt0), 32'h8);
        b0.dout_ready = 1'b1;
        tick(1);
        b0.dout_ready = 1'b0;
        chk("pp_count", 32'(cnt0), 32'h8);
        chk("pp_ovf", 32'(ovf0), 32'h0);
        b0.dout_ready = 1'b1;
        for (int i = 2; i <= 8; i++) begin
            chk("pp_drain", b0.dout, 32'(32'h10 + i));
            tick(1);
        end
        chk("pp_last", b0.dout, 32'h99);
        tick(1);
        chk("pp_empty", 32'(b0.dout_valid), 32'h0);
        b0.dout_ready = 1'b0;
        yin = 16'h0042;
        tick(82);
        chk("three_buf", 32'(cnt0), 32'h3);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_count", 32'(cnt0), 32'h0);
        chk("mid_rst_valid", 32'(b0.dout_valid), 32'h0);
        chk("mid_rst_ovf", 32'(ovf0), 32'h0);
        chk("mid_rst_cc", 32'(cc0), 32'h0);
        chk("mid_rst_dout", b0.dout, 32'h0);
        rst = 1'b0;
        en = 1'b1;
        tick(5);
        en = 1'b0;
        tick(10);
        chk("gate_cc", 32'(cc0), 32'h0);
        en = 1'b1;
        tick(24);
        chk("gate_cc_before", 32'(cc0), 32'h0);
        tick(1);
        chk("gate_cc_capture", 32'(cc0), 32'h1);
        en = 1'b0;
        tick(1);
        chk("gate_push", 32'(cnt0), 32'h1);
        chk("gate_dout", b0.dout, 32'h00000042);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
